// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock through a stored carry.
// Optional signed-overflow output enabled by defining SEQ_ADDSUB_OVF_EN.
module seq_addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SEQ_ADDSUB_OVF_EN
  ,output logic            ovf
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] a_shift, b_shift, acc_shift;
`ifdef SEQ_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Operands shift right so the active slice is always the low CHUNK bits;
  // the accumulator fills from the top, landing slice 0 at bit 0 after N steps.
  generate
    if (N == 1) begin : g_one
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign acc_shift = slice_s;
    end else begin : g_multi
      assign a_shift   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_shift   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
      assign acc_shift = {slice_s, acc_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  seq_addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SEQ_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~c0 : c0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_shift;
        b_d     = b_shift;
        acc_d   = acc_shift;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = acc_shift;
          cout_d  = slice_co;
`ifdef SEQ_ADDSUB_OVF_EN
          // carry into the MSB is recovered as a ^ b ^ sum at that bit
          ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_s[CHUNK-1] ^ slice_co;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SEQ_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
`ifdef SEQ_ADDSUB_OVF_EN
  assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed table, handshake/abort sequences,
// random ops against an integer-arithmetic model, plus a WIDTH=4/CHUNK=1 instance.
module tb_seq_addsub;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, c0, sub;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] s;
  logic       start2, c02, sub2;
  logic [3:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [3:0] s2;
`ifdef SEQ_ADDSUB_OVF_EN
  logic       ovf, ovf2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c0(c0), .sub(sub),
    .busy(busy), .done(done), .s(s), .cout(cout)
`ifdef SEQ_ADDSUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  seq_addsub #(.WIDTH(4), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c0(c02), .sub(sub2),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2)
`ifdef SEQ_ADDSUB_OVF_EN
    , .ovf(ovf2)
`endif
  );

  typedef struct {
    logic [7:0] a, b;
    logic       c0, sub;
    logic [7:0] s;
    logic       cout, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer add/subtract, modulo 2^w; signed overflow from range check.
  function automatic void model(input int w, input int ta, input int tb, input int tc,
                                input int ts, output int es, output int ec, output int eo);
    int r, m, sa, sb, sr;
    m  = 1 << w;
    r  = ts ? (ta - tb - tc) : (ta + tb + tc);
    ec = ts ? int'(r >= 0) : int'(r >= m);
    es = ((r % m) + m) % m;
    sa = (ta >= m / 2) ? ta - m : ta;
    sb = (tb >= m / 2) ? tb - m : tb;
    sr = ts ? (sa - sb - tc) : (sa + sb + tc);
    eo = int'(sr >= m / 2 || sr < -(m / 2));
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, input logic [7:0] es,
                        input logic ec, input logic eo);
    logic [7:0] prev_s;
    int n;
    prev_s = s;
    a = ta; b = tb; c0 = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c0 = 1'($urandom); sub = 1'($urandom);
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " s_hold"}, s, prev_s);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 2);
    chk({tag, " s"}, s, es);
    chk({tag, " cout"}, cout, ec);
`ifdef SEQ_ADDSUB_OVF_EN
    chk({tag, " ovf"}, ovf, eo);
`endif
    @(posedge clk); #1;
    chk({tag, " pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic run_op2(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                         input logic tc, input logic ts);
    int es, ec, eo, n;
    model(4, int'(ta), int'(tb), int'(tc), int'(ts), es, ec, eo);
    a2 = ta; b2 = tb; c02 = tc; sub2 = ts; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = 4'($urandom); b2 = 4'($urandom);
    n = 0;
    while (!done2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " s"}, s2, es[3:0]);
    chk({tag, " cout"}, cout2, ec[0]);
`ifdef SEQ_ADDSUB_OVF_EN
    chk({tag, " ovf"}, ovf2, eo[0]);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int es, ec, eo;
    logic seen;
    logic [7:0] ra, rb;
    logic rc, rs;

    vt[0] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h04, 8'h07, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b0};
    vt[3] = '{8'h0B, 8'h04, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[4] = '{8'h04, 8'h07, 1'b0, 1'b1, 8'hFD, 1'b0, 1'b0};
    vt[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

    // reset with random inputs
    rst_n = 1'b0;
    start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); c0 = 1'($urandom); sub = 1'($urandom);
    start2 = 1'b0; a2 = '0; b2 = '0; c02 = 1'b0; sub2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst s", s, 8'h00);
    chk("rst cout", cout, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle after rst", {busy, done, cout, s}, 11'h0);
    end

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].c0, vt[i].sub,
             vt[i].s, vt[i].cout, vt[i].ovf);

    // start held high: operands captured at accept, re-accept exactly N+2 edges later
    a = 8'h10; b = 8'h20; c0 = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("hold busy0", busy, 1'b1);
    a = 8'h55;
    @(posedge clk); #1;
    chk("hold busy1", {busy, done}, 2'b10);
    @(posedge clk); #1;
    chk("hold done", {busy, done}, 2'b01);
    chk("hold s", s, 8'h30);
    @(posedge clk); #1;
    chk("hold idle", {busy, done}, 2'b00);
    @(posedge clk); #1;
    chk("hold reaccept", busy, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold second done", done, 1'b1);
    chk("hold second s", s, 8'h75);
    @(posedge clk); #1;

    // no done without acceptance
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    chk("no spurious done", seen, 1'b0);

    // reset mid-operation aborts
    a = 8'h12; b = 8'h34; c0 = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort state", {busy, done, cout}, 3'b000);
    chk("abort s", s, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    chk("abort no done", seen, 1'b0);
    chk("abort s kept", s, 8'h00);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i < 4) rb = (i[0]) ? 8'hFF : 8'h00;
      model(8, int'(ra), int'(rb), int'(rc), int'(rs), es, ec, eo);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, es[7:0], ec[0], eo[0]);
    end

    run_op2("w4 F+1", 4'hF, 4'h1, 1'b0, 1'b0);
    chk("w4 F+1 exact s", s2, 4'h0);
    chk("w4 F+1 exact cout", cout2, 1'b1);
    for (int i = 0; i < 12; i++)
      run_op2($sformatf("w4 rnd%0d", i), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
